apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Round-robin arbiter that shares the single APB master's internal request port (transfer/addr/wdata/write → ready/rdata) among up to NUM_REQ requesters, such as the CPU load/store unit and a DMA engine. It picks one pending requester, drives a one-cycle `transfer` pulse with latched address, data and direction, then tracks the master through SETUP and ACCESS. When the slave answers, it returns read data with a one-cycle `done` pulse to the granted requester. It sits between the requesters and the APB master and has no direct APB pins.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT, 255, ACCESS cycles before the sticky `timeout` flag sets (8-bit counter)

- PCLK  in  1  clock
- PRESETn  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester request, held until its `done`
- req_addr  in  NUM_REQ×32  per-requester address
- req_wdata  in  NUM_REQ×32  per-requester write data
- req_write  in  NUM_REQ  1 = write, 0 = read
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- rdata  out  32  read data, valid while `done` ≠ 0
- m_transfer  out  1  transfer trigger to the master
- m_addr, m_wdata  out  32 each  latched request to the master
- m_write  out  1  latched direction
- m_ready  in  1  master ready
- m_rdata  in  32  master read data
- busy  out  1  state ≠ IDLE
- timeout  out  1  sticky; set when ACCESS lasts TIMEOUT cycles
- timeout_clr  in  1  clears `timeout`

## Operation
- States: IDLE, ISSUE, SETUP, ACCESS, RESP.
- IDLE: if any `req` is set, the round-robin picker selects one, starting at ptr+1 and wrapping.
  - Register `gnt`.
  - Latch that requester's addr, wdata and write into m_addr, m_wdata and m_write.
  - Go to ISSUE.
- ISSUE: m_transfer=1 for exactly this cycle. → SETUP.
- SETUP: ignore m_ready, because the master's ready can be high early. → ACCESS.
- ACCESS: wait for m_ready=1.
  - On m_ready=1, latch m_rdata into rdata (for writes too) and go to RESP.
- RESP: done[g]=1, rdata held, gnt held.
  - ptr ← granted index.
  - Next state IDLE with gnt=0.
- Requester rules:
  - Keep req, addr, wdata and write stable from req=1 until done.
  - Drop req at the edge that ends RESP if no further transfer is wanted.
  - A req still high in IDLE is a new request.
- m_addr, m_wdata and m_write change only on grant in IDLE and hold until the next grant.
- Timeout counter:
  - Clears on entry to ACCESS and counts each ACCESS cycle, saturating.
  - At count==TIMEOUT, `timeout` ← 1. The FSM stays in ACCESS; there is no abort.
  - timeout_clr clears `timeout`. If set and clear occur in the same cycle, set wins.
- A req that drops while not granted is ignored. A req that drops while granted does not abort; the transaction completes.

## Timing
- Reset values: state=IDLE; gnt, done, rdata, m_transfer, m_addr, m_wdata, m_write, busy and timeout all 0; ptr=NUM_REQ−1, so req[0] wins first.
- Reset asserted mid-transaction: everything returns to the reset values immediately. The master is reset by the same reset.
- Zero-wait slave, req sampled high at IDLE edge t:
  - ISSUE at t+1 (m_transfer=1).
  - SETUP at t+2.
  - ACCESS at t+3.
  - RESP/done at t+4.
  - Back-to-back transactions occupy 5 cycles each.
- Slave with W wait cycles: done at t+4+W.
- All outputs are registered, except that m_transfer, busy and done decode directly from the state register and the gnt register.

## Structure
- Package apb_arb_pkg holds:
  - the state enum `arb_state_e` (IDLE, ISSUE, SETUP, ACCESS, RESP);
  - a NUM_REQ_MAX=8 constant;
  - the APB slot address constants 32'h1000_0000 + n·32'h1000 used by the benches.
- Sub-module rr_picker: combinational. Inputs are req and ptr; outputs are a one-hot grant and a valid flag.

## Test plan
- Single read: req[0]=1, addr=32'h1000_1004, slave returns 32'hDEAD_BEEF with no wait. Required: m_transfer at t+1; done[0] and rdata=32'hDEAD_BEEF at t+4.
- Single write: req[2]=1, addr=32'h1000_2000, wdata=32'h1234_5678. Required: m_write=1 and m_wdata=32'h1234_5678 stable from ISSUE to RESP; done[2] at t+4.
- Fairness: req[0..3] all held high for 8 transactions. Required grant order 0,1,2,3,0,1,2,3.
- Early ready: slave PREADY tied high, so m_ready=1 during SETUP. Required: the arbiter does not leave SETUP early, and done still arrives at t+4.
- Timeout: slave PREADY held low for 300 cycles with TIMEOUT=255. Required: `timeout` rises after 255 ACCESS cycles and the FSM stays in ACCESS. When PREADY rises, done is produced. timeout_clr then clears the flag.
- Reset mid-ACCESS: PRESETn driven low. Required: all outputs read 0 in that cycle, and after release the next request is granted to req[0].

Source files
------------

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg
// Shared definitions for the APB request arbiter:
//   arb_state_e   - arbiter FSM states
//   NUM_REQ_MAX   - largest supported number of requesters
//   SLOT_BASE / SLOT_STRIDE / slot_addr() - APB slave slot address map
package apb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4
  } arb_state_e;

  localparam int NUM_REQ_MAX = 8;

  localparam logic [31:0] SLOT_BASE   = 32'h1000_0000;
  localparam logic [31:0] SLOT_STRIDE = 32'h0000_1000;

  // Base address of APB slave slot n.
  function automatic logic [31:0] slot_addr(input int n);
    return SLOT_BASE + (32'(n) * SLOT_STRIDE);
  endfunction

endpackage

// File: rtl/apb_req_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin selector. The search starts at the requester
// after ptr and wraps around, so the most recently served requester has
// the lowest priority.
// Ports:
//   req   in  NUM_REQ  pending requests
//   ptr   in  PTR_W    index of the last served requester
//   gnt   out NUM_REQ  one-hot selection (all zero when nothing pending)
//   valid out 1        at least one request pending
module rr_picker
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  // Walk NUM_REQ positions starting at ptr+1; the first pending request
  // found wins. The explicit wrap keeps this correct for counts that are
  // not a power of two.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == PTR_W'(NUM_REQ - 1)) begin
        idx = '0;
      end else begin
        idx = idx + 1'b1;
      end
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
// Shares the APB master's internal request port among NUM_REQ requesters
// using round-robin arbitration. A granted request is latched, handed to
// the master with a one-cycle transfer pulse, followed through SETUP and
// ACCESS, and completed with a one-cycle done pulse carrying read data.
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   req/req_addr/req_wdata/req_write  per-requester request
//   gnt                    one-hot grant held for the whole transaction
//   done                   one-cycle completion pulse to the granted requester
//   rdata                  read data, valid while done != 0
//   m_transfer/m_addr/m_wdata/m_write  request to the APB master
//   m_ready/m_rdata        response from the APB master
//   busy                   arbiter not idle
//   timeout/timeout_clr    sticky ACCESS timeout flag and its clear
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0] req_wdata,
  input  logic [NUM_REQ-1:0]       req_write,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [31:0]              rdata,
  output logic                     m_transfer,
  output logic [31:0]              m_addr,
  output logic [31:0]              m_wdata,
  output logic                     m_write,
  input  logic                     m_ready,
  input  logic [31:0]              m_rdata,
  output logic                     busy,
  output logic                     timeout,
  input  logic                     timeout_clr
);

  localparam int          PTR_W       = $clog2(NUM_REQ);
  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

  arb_state_e        state;
  arb_state_e        state_next;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  cur_idx;
  logic [PTR_W-1:0]  pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic              pick_valid;
  logic [7:0]        tmo_cnt;
  logic [7:0]        tmo_inc;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Binary index of the picked requester, used to select its payload.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. SETUP always advances unconditionally because the
  // master may already show ready before the access phase begins.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (pick_valid) state_next = ISSUE;
      ISSUE:   state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (m_ready) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded straight from the state and grant registers.
  always_comb begin
    m_transfer = (state == ISSUE);
    busy       = (state != IDLE);
    done       = (state == RESP) ? gnt : '0;
  end

  // Grant, request latch, read data and round-robin pointer. The master-side
  // request only changes on a new grant, so it stays stable through the
  // whole transaction.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      gnt     <= '0;
      cur_idx <= '0;
      ptr     <= PTR_W'(NUM_REQ - 1);
      m_addr  <= '0;
      m_wdata <= '0;
      m_write <= 1'b0;
      rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt     <= pick_gnt;
            cur_idx <= pick_idx;
            m_addr  <= req_addr[pick_idx];
            m_wdata <= req_wdata[pick_idx];
            m_write <= req_write[pick_idx];
          end
        end
        ACCESS: begin
          if (m_ready) begin
            rdata <= m_rdata;
          end
        end
        RESP: begin
          gnt <= '0;
          ptr <= cur_idx;
        end
        default: ;
      endcase
    end
  end

  // Saturating ACCESS-cycle counter, restarted while passing through SETUP.
  assign tmo_inc = (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS) begin
      tmo_cnt <= tmo_inc;
    end
  end

  // Sticky timeout flag; a set in the same cycle as a clear takes priority.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      timeout <= 1'b0;
    end else if ((state == ACCESS) && (tmo_inc == TIMEOUT_CNT)) begin
      timeout <= 1'b1;
    end else if (timeout_clr) begin
      timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter
// Directed bench for apb_req_arbiter: a table of single transactions with
// hand-computed grants, latched payloads and completion timing, followed by
// hand-written timeout and mid-transaction reset sequences.
module tb_apb_req_arbiter;
  import apb_arb_pkg::*;

  logic             PCLK;
  logic             PRESETn;
  logic [3:0]       req;
  logic [3:0][31:0] req_addr;
  logic [3:0][31:0] req_wdata;
  logic [3:0]       req_write;
  logic [3:0]       gnt;
  logic [3:0]       done;
  logic [31:0]      rdata;
  logic             m_transfer;
  logic [31:0]      m_addr;
  logic [31:0]      m_wdata;
  logic             m_write;
  logic             m_ready;
  logic [31:0]      m_rdata;
  logic             busy;
  logic             timeout;
  logic             timeout_clr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  mask;
    int          waits;
    logic [31:0] slv_rdata;
    logic [3:0]  exp_gnt;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_write;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  apb_req_arbiter #(
    .NUM_REQ (4),
    .TIMEOUT (255)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .req         (req),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_write   (req_write),
    .gnt         (gnt),
    .done        (done),
    .rdata       (rdata),
    .m_transfer  (m_transfer),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_write     (m_write),
    .m_ready     (m_ready),
    .m_rdata     (m_rdata),
    .busy        (busy),
    .timeout     (timeout),
    .timeout_clr (timeout_clr)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Runs one transaction from IDLE: request at edge 1, transfer pulse after
  // it, SETUP, ACCESS with v.waits wait cycles, done 4+waits edges later.
  task automatic applyStimulus(input int n, input vec_t v);
    req     = v.mask;
    m_rdata = v.slv_rdata;
    m_ready = (v.waits == 0);
    tick();
    checkOutput($sformatf("v%0d issue transfer", n), 32'(m_transfer), 32'd1);
    checkOutput($sformatf("v%0d issue gnt", n), 32'(gnt), 32'(v.exp_gnt));
    checkOutput($sformatf("v%0d issue busy", n), 32'(busy), 32'd1);
    checkOutput($sformatf("v%0d issue addr", n), m_addr, v.exp_addr);
    checkOutput($sformatf("v%0d issue wdata", n), m_wdata, v.exp_wdata);
    checkOutput($sformatf("v%0d issue write", n), 32'(m_write), 32'(v.exp_write));
    tick();
    checkOutput($sformatf("v%0d setup transfer", n), 32'(m_transfer), 32'd0);
    checkOutput($sformatf("v%0d setup done", n), 32'(done), 32'd0);
    tick();
    checkOutput($sformatf("v%0d access done", n), 32'(done), 32'd0);
    for (int k = 0; k < v.waits; k++) begin
      tick();
      checkOutput($sformatf("v%0d wait%0d done", n, k), 32'(done), 32'd0);
    end
    m_ready = 1'b1;
    tick();
    checkOutput($sformatf("v%0d resp done", n), 32'(done), 32'(v.exp_gnt));
    checkOutput($sformatf("v%0d resp rdata", n), rdata, v.slv_rdata);
    checkOutput($sformatf("v%0d resp gnt", n), 32'(gnt), 32'(v.exp_gnt));
    checkOutput($sformatf("v%0d resp wdata", n), m_wdata, v.exp_wdata);
    checkOutput($sformatf("v%0d resp write", n), 32'(m_write), 32'(v.exp_write));
    req = 4'b0000;
    tick();
    checkOutput($sformatf("v%0d idle busy", n), 32'(busy), 32'd0);
    checkOutput($sformatf("v%0d idle gnt", n), 32'(gnt), 32'd0);
    checkOutput($sformatf("v%0d idle done", n), 32'(done), 32'd0);
  endtask

  initial begin
    PRESETn     = 1'b0;
    req         = 4'b0000;
    m_ready     = 1'b0;
    m_rdata     = '0;
    timeout_clr = 1'b0;
    req_addr[0] = slot_addr(1) + 32'h4;
    req_addr[1] = slot_addr(1) + 32'h8;
    req_addr[2] = slot_addr(2);
    req_addr[3] = slot_addr(3);
    req_wdata[0] = 32'h0000_0000;
    req_wdata[1] = 32'hAAAA_0001;
    req_wdata[2] = 32'h1234_5678;
    req_wdata[3] = 32'hCAFE_0003;
    req_write    = 4'b1100;

    // Fairness: all four held, pointer starts at 3 so order is 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      vecs[i].mask      = 4'b1111;
      vecs[i].waits     = 0;
      vecs[i].slv_rdata = 32'h1111_0000 + 32'(i);
    end
    vecs[0].exp_gnt = 4'b0001; vecs[4].exp_gnt = 4'b0001;
    vecs[1].exp_gnt = 4'b0010; vecs[5].exp_gnt = 4'b0010;
    vecs[2].exp_gnt = 4'b0100; vecs[6].exp_gnt = 4'b0100;
    vecs[3].exp_gnt = 4'b1000; vecs[7].exp_gnt = 4'b1000;
    for (int i = 0; i < 8; i += 4) begin
      vecs[i].exp_addr   = 32'h1000_1004; vecs[i].exp_wdata   = 32'h0000_0000; vecs[i].exp_write   = 1'b0;
      vecs[i+1].exp_addr = 32'h1000_1008; vecs[i+1].exp_wdata = 32'hAAAA_0001; vecs[i+1].exp_write = 1'b0;
      vecs[i+2].exp_addr = 32'h1000_2000; vecs[i+2].exp_wdata = 32'h1234_5678; vecs[i+2].exp_write = 1'b1;
      vecs[i+3].exp_addr = 32'h1000_3000; vecs[i+3].exp_wdata = 32'hCAFE_0003; vecs[i+3].exp_write = 1'b1;
    end
    // Single read, early ready (m_ready high from ISSUE on).
    vecs[8]  = '{4'b0001, 0, 32'hDEAD_BEEF, 4'b0001, 32'h1000_1004, 32'h0000_0000, 1'b0};
    // Single write.
    vecs[9]  = '{4'b0100, 0, 32'h0000_5A5A, 4'b0100, 32'h1000_2000, 32'h1234_5678, 1'b1};
    // Slave wait states.
    vecs[10] = '{4'b0010, 3, 32'h0BAD_F00D, 4'b0010, 32'h1000_1008, 32'hAAAA_0001, 1'b0};
    // Mixed masks: ptr 1 -> 3, ptr 3 -> 1, ptr 1 -> 0, ptr 0 -> 2.
    vecs[11] = '{4'b1001, 1, 32'h0000_0011, 4'b1000, 32'h1000_3000, 32'hCAFE_0003, 1'b1};
    vecs[12] = '{4'b0110, 0, 32'h0000_0012, 4'b0010, 32'h1000_1008, 32'hAAAA_0001, 1'b0};
    vecs[13] = '{4'b0011, 2, 32'h0000_0013, 4'b0001, 32'h1000_1004, 32'h0000_0000, 1'b0};
    vecs[14] = '{4'b1100, 0, 32'h0000_0014, 4'b0100, 32'h1000_2000, 32'h1234_5678, 1'b1};

    #12;
    checkOutput("reset gnt", 32'(gnt), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset rdata", rdata, 32'd0);
    checkOutput("reset transfer", 32'(m_transfer), 32'd0);
    checkOutput("reset addr", m_addr, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset timeout", 32'(timeout), 32'd0);
    tick();
    PRESETn = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Timeout: ACCESS entered after edge 3, flag rises at edge 3+255.
    $display("[TB] timeout sequence");
    req     = 4'b0001;
    m_ready = 1'b0;
    m_rdata = 32'hFEED_0001;
    repeat (3) tick();
    for (int k = 0; k < 254; k++) tick();
    checkOutput("tmo before", 32'(timeout), 32'd0);
    tick();
    checkOutput("tmo rise", 32'(timeout), 32'd1);
    checkOutput("tmo still busy", 32'(busy), 32'd1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    checkOutput("tmo set wins", 32'(timeout), 32'd1);
    repeat (41) tick();
    checkOutput("tmo hold busy", 32'(busy), 32'd1);
    checkOutput("tmo hold done", 32'(done), 32'd0);
    checkOutput("tmo hold transfer", 32'(m_transfer), 32'd0);
    m_ready = 1'b1;
    tick();
    checkOutput("tmo done", 32'(done), 32'h1);
    checkOutput("tmo rdata", rdata, 32'hFEED_0001);
    req = 4'b0000;
    tick();
    checkOutput("tmo sticky", 32'(timeout), 32'd1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    checkOutput("tmo cleared", 32'(timeout), 32'd0);

    // Reset in the middle of ACCESS.
    $display("[TB] reset sequence");
    req     = 4'b0100;
    m_ready = 1'b0;
    repeat (3) tick();
    checkOutput("rst pre gnt", 32'(gnt), 32'h4);
    checkOutput("rst pre addr", m_addr, 32'h1000_2000);
    repeat (2) tick();
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("rst gnt", 32'(gnt), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst rdata", rdata, 32'd0);
    checkOutput("rst transfer", 32'(m_transfer), 32'd0);
    checkOutput("rst addr", m_addr, 32'd0);
    checkOutput("rst wdata", m_wdata, 32'd0);
    checkOutput("rst write", 32'(m_write), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst timeout", 32'(timeout), 32'd0);
    tick();
    PRESETn = 1'b1;
    req     = 4'b1111;
    m_ready = 1'b1;
    m_rdata = 32'h0000_00AB;
    tick();
    checkOutput("post rst gnt", 32'(gnt), 32'h1);
    checkOutput("post rst transfer", 32'(m_transfer), 32'd1);
    repeat (3) tick();
    checkOutput("post rst done", 32'(done), 32'h1);
    checkOutput("post rst rdata", rdata, 32'h0000_00AB);
    req = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
